// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register + imem req/ack fetch FSM; ports clk/rst, PC_result/stall in, imem_req/addr/ack/rdata bus, Instruction/inst_valid/PC/PC_next/bus_err/misalign out; option PC_MISALIGN_TRAP_EN
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
  parameter int          WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_result,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_next,
  output logic        bus_err,
  output logic        misalign
);
  typedef enum logic [1:0] {RESET, FETCH, EXEC, ERROR} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [31:0] pc_n, inst_n, target;
  logic valid_n, err_n, bad;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  assign imem_addr = PC;
  assign PC_next = PC + 32'd4;
  assign bad = TRAP_EN && (PC_result[1:0] != 2'b00);
  assign target = bad ? TRAP_PC : {PC_result[31:2], 2'b00};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_n = PC;
    inst_n = Instruction;
    valid_n = inst_valid;
    err_n = bus_err;
    case (state)
      RESET: state_n = FETCH;
      FETCH: begin
        if (imem_ack) begin
          inst_n = imem_rdata;
          valid_n = 1'b1;
          cnt_n = 8'd0;
          state_n = EXEC;
        end else if (cnt == 8'(WAIT_MAX - 1)) begin
          err_n = 1'b1;
          cnt_n = 8'd0;
          state_n = ERROR;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_n = target;
          inst_n = 32'h0;
          valid_n = 1'b0;
          state_n = FETCH;
        end
      end
      default: state_n = ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET;
      cnt <= 8'd0;
      PC <= RESET_PC;
      Instruction <= 32'h0;
      inst_valid <= 1'b0;
      imem_req <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      PC <= pc_n;
      Instruction <= inst_n;
      inst_valid <= valid_n;
      imem_req <= state_n == FETCH;
      bus_err <= err_n;
    end
  end
`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    misalign <= !rst && state == EXEC && !stall && bad;
  end
`else
  assign misalign = 1'b0;
`endif
endmodule
